fb_write_arbiter: RTL and testbench



---
 rtl/fb_write_arbiter.sv | 93 +++++++++
 tb/tb_fb_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin framebuffer write-port arbiter for two requesters plus a whole-frame clear engine
module fb_write_arbiter #(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int SCALING_FACTOR = 1,
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  clear_busy,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  fb_en_wr,
    output logic                  fb_wrea,
    output logic [ADDR_WIDTH-1:0] fb_addr_wr,
    output logic [DATA_WIDTH-1:0] fb_din,
    output logic [15:0]           drop_cnt
);
    localparam int NUM = FRAME_WIDTH / SCALING_FACTOR * FRAME_HEIGHT / SCALING_FACTOR;
    localparam logic [ADDR_WIDTH:0]   NUM_W = (ADDR_WIDTH + 1)'(NUM);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM - 1);

    if (NUM < 2 ** (ADDR_WIDTH - 1) || NUM > 2 ** ADDR_WIDTH) begin : g_bad_cfg
        $error("fb_write_arbiter: ADDR_WIDTH does not fit the stored pixel count");
    end

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic                  last_b;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] color;
    logic                  open;
    logic [ADDR_WIDTH-1:0] hs_addr;
    logic [DATA_WIDTH-1:0] hs_data;

    // a pending clear_start blocks grants so the request stays queued at its source
    assign open       = state == IDLE && !clear_start;
    assign a_ready    = open && a_valid && (!b_valid || last_b);
    assign b_ready    = open && b_valid && (!a_valid || !last_b);
    assign hs_addr    = b_ready ? b_addr : a_addr;
    assign hs_data    = b_ready ? b_data : a_data;
    assign fb_wrea    = fb_en_wr;
    assign clear_busy = state == CLEAR;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_b     <= 1'b1;
            cnt        <= '0;
            color      <= '0;
            fb_en_wr   <= 1'b0;
            fb_addr_wr <= '0;
            fb_din     <= '0;
            drop_cnt   <= '0;
        end else begin
            fb_en_wr <= 1'b0;
            if (state == CLEAR) begin
                fb_en_wr   <= 1'b1;
                fb_addr_wr <= cnt;
                fb_din     <= color;
                if (cnt == LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (clear_start) begin
                state <= CLEAR;
                color <= clear_color;
                cnt   <= '0;
            end else if (a_ready || b_ready) begin
                last_b <= b_ready;
                if ({1'b0, hs_addr} < NUM_W) begin
                    fb_en_wr   <= 1'b1;
                    fb_addr_wr <= hs_addr;
                    fb_din     <= hs_data;
                end else if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: vector table, directed clear/reset sequences and a randomized run against a transaction-level model
module tb_fb_write_arbiter;
    localparam int AW  = 6;
    localparam int DW  = 8;
    localparam int NUM = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear_start;
    logic [DW-1:0] clear_color;
    logic          clear_busy;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          fb_en_wr, fb_wrea;
    logic [AW-1:0] fb_addr_wr;
    logic [DW-1:0] fb_din;
    logic [15:0]   drop_cnt;

    // 6-bit addresses make out-of-range requests (>= 32) expressible
    fb_write_arbiter #(
        .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .SCALING_FACTOR(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .fb_en_wr(fb_en_wr), .fb_wrea(fb_wrea), .fb_addr_wr(fb_addr_wr), .fb_din(fb_din),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          av, bv;
        logic [AW-1:0] aa, ba;
        logic [DW-1:0] ad, bd;
        logic          ear, ebr, een;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edin;
        logic [15:0]   edrop;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t          vecs[10];
    wr_t           exp_q[$];
    wr_t           w;
    logic [DW-1:0] mem_exp[NUM];
    logic [DW-1:0] mem_act[NUM];
    int            n_chk = 0;
    int            n_fail = 0;
    int            blk_end, clr_t, drops, en_cnt;
    bit            served_b, ea, eb, idle, act;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        n_chk++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        a_valid = 1'b0; b_valid = 1'b0; clear_start = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; clear_color = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 6'd3,  6'd0,  8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 6'd4,  6'd5,  8'h22, 8'h33, 1'b0, 1'b1, 1'b1, 6'd3,  8'h11, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 6'd4,  6'd6,  8'h22, 8'h44, 1'b1, 1'b0, 1'b1, 6'd5,  8'h33, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 6'd7,  6'd6,  8'h55, 8'h44, 1'b0, 1'b1, 1'b1, 6'd4,  8'h22, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 6'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 6'd6,  8'h44, 16'd0};
        vecs[5] = '{1'b0, 1'b1, 6'd0,  6'd40, 8'h00, 8'h66, 1'b0, 1'b1, 1'b0, 6'd6,  8'h44, 16'd0};
        vecs[6] = '{1'b1, 1'b0, 6'd31, 6'd0,  8'h77, 8'h00, 1'b1, 1'b0, 1'b0, 6'd6,  8'h44, 16'd1};
        vecs[7] = '{1'b0, 1'b0, 6'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 6'd31, 8'h77, 16'd1};
        vecs[8] = '{1'b0, 1'b1, 6'd0,  6'd32, 8'h00, 8'h88, 1'b0, 1'b1, 1'b0, 6'd31, 8'h77, 16'd1};
        vecs[9] = '{1'b0, 1'b0, 6'd0,  6'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 6'd31, 8'h77, 16'd2};

        rst_n = 1'b0;
        quiet();
        do_reset();
        #1;
        chk("rst_en_wr", fb_en_wr, 0);
        chk("rst_wrea", fb_wrea, 0);
        chk("rst_addr", fb_addr_wr, 0);
        chk("rst_din", fb_din, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_a_ready_idle", a_ready, 0);
        step();

        // arbitration, latency, hold and out-of-range drops
        for (int i = 0; i < 10; i++) begin
            a_valid = vecs[i].av; b_valid = vecs[i].bv;
            a_addr = vecs[i].aa; b_addr = vecs[i].ba;
            a_data = vecs[i].ad; b_data = vecs[i].bd;
            #1;
            chk($sformatf("vec%0d_a_ready", i), a_ready, vecs[i].ear);
            chk($sformatf("vec%0d_b_ready", i), b_ready, vecs[i].ebr);
            chk($sformatf("vec%0d_en_wr", i), fb_en_wr, vecs[i].een);
            chk($sformatf("vec%0d_wrea", i), fb_wrea, vecs[i].een);
            chk($sformatf("vec%0d_addr", i), fb_addr_wr, vecs[i].eaddr);
            chk($sformatf("vec%0d_din", i), fb_din, vecs[i].edin);
            chk($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].edrop);
            step();
        end
        quiet();

        // clear with a same-cycle pending A request and an ignored restart at t+10
        clear_start = 1'b1; clear_color = 8'h5A;
        a_valid = 1'b1; a_addr = 6'd3; a_data = 8'h11;
        #1;
        chk("clr_t0_a_ready", a_ready, 0);
        step();
        for (int j = 1; j <= 35; j++) begin
            clear_start = (j == 10);
            clear_color = (j == 10) ? 8'hA5 : 8'h5A;
            a_valid = (j <= 33);
            #1;
            chk($sformatf("clr_t%0d_busy", j), clear_busy, (j >= 1 && j <= 32));
            chk($sformatf("clr_t%0d_a_ready", j), a_ready, (j == 33));
            chk($sformatf("clr_t%0d_en_wr", j), fb_en_wr, ((j >= 2 && j <= 33) || j == 34));
            if (j >= 2 && j <= 34) begin
                chk($sformatf("clr_t%0d_addr", j), fb_addr_wr, (j <= 33) ? j - 2 : 3);
                chk($sformatf("clr_t%0d_din", j), fb_din, (j <= 33) ? 8'h5A : 8'h11);
            end
            step();
        end
        quiet();

        // reset taking effect at the edge that starts t+12 aborts the fill after address 9
        clear_start = 1'b1; clear_color = 8'hC3;
        step();
        clear_start = 1'b0;
        for (int j = 1; j <= 14; j++) begin
            rst_n = (j != 11);
            a_valid = (j == 13); a_addr = 6'd20; a_data = 8'h99;
            #1;
            chk($sformatf("rmc_t%0d_busy", j), clear_busy, (j >= 1 && j <= 11));
            chk($sformatf("rmc_t%0d_en_wr", j), fb_en_wr, ((j >= 2 && j <= 11) || j == 14));
            if (j >= 2 && j <= 11) chk($sformatf("rmc_t%0d_addr", j), fb_addr_wr, j - 2);
            if (j == 13) chk("rmc_idle_a_ready", a_ready, 1);
            if (j == 14) begin
                chk("rmc_post_addr", fb_addr_wr, 20);
                chk("rmc_post_din", fb_din, 8'h99);
            end
            step();
        end
        quiet();

        // randomized run against an ordered write queue and a framebuffer image
        do_reset();
        served_b = 1'b1; drops = 0; blk_end = -1; clr_t = -1;
        exp_q.delete();
        for (int i = 0; i < NUM; i++) begin
            mem_exp[i] = '0;
            mem_act[i] = '0;
        end
        for (int c = 0; c < 2040; c++) begin
            act = (c < 2000);
            a_valid = act && ($urandom_range(0, 2) != 0);
            b_valid = act && ($urandom_range(0, 2) != 0);
            a_addr = 6'($urandom_range(0, 40));
            b_addr = 6'($urandom_range(0, 40));
            a_data = 8'($urandom);
            b_data = 8'($urandom);
            clear_start = act && ($urandom_range(0, 59) == 0);
            clear_color = 8'($urandom);
            #1;
            idle = (c > blk_end);
            ea = idle && !clear_start && a_valid && (!b_valid || served_b);
            eb = idle && !clear_start && b_valid && (!a_valid || !served_b);
            chk("rand_a_ready", a_ready, ea);
            chk("rand_b_ready", b_ready, eb);
            chk("rand_busy", clear_busy, (c > clr_t && c <= blk_end));
            chk("rand_drop", drop_cnt, drops);
            if (fb_en_wr) begin
                chk("rand_write_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("rand_wr_addr", fb_addr_wr, w.addr);
                    chk("rand_wr_data", fb_din, w.data);
                end
                if (fb_addr_wr < NUM) mem_act[fb_addr_wr[4:0]] = fb_din;
            end
            if (idle && clear_start) begin
                clr_t = c;
                blk_end = c + NUM;
                for (int k = 0; k < NUM; k++) begin
                    exp_q.push_back('{6'(k), clear_color});
                    mem_exp[k] = clear_color;
                end
            end else if (ea || eb) begin
                served_b = eb;
                g_addr = eb ? b_addr : a_addr;
                g_data = eb ? b_data : a_data;
                if (g_addr < NUM) begin
                    exp_q.push_back('{g_addr, g_data});
                    mem_exp[g_addr[4:0]] = g_data;
                end else if (drops < 65535) begin
                    drops++;
                end
            end
            step();
        end
        chk("rand_queue_drained", exp_q.size(), 0);
        for (int i = 0; i < NUM; i++) chk($sformatf("rand_mem%0d", i), mem_act[i], mem_exp[i]);
        quiet();

        // drop counter saturation
        do_reset();
        en_cnt = 0;
        for (int i = 0; i < 70000; i++) begin
            a_valid = 1'b1;
            a_addr = 6'(32 + i % 32);
            a_data = 8'(i);
            #1;
            if (fb_en_wr) en_cnt++;
            if (i == 1000) chk("sat_drop_1000", drop_cnt, 1000);
            if (i == 65535) chk("sat_drop_65535", drop_cnt, 65535);
            step();
        end
        quiet();
        #1;
        chk("sat_drop_final", drop_cnt, 16'hFFFF);
        chk("sat_no_writes", en_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
